serial_alu_ctrl: RTL
====================

# serial_alu_ctrl

Bit-serial ALU sequencer. It runs a full WIDTH-bit operation through a single one-bit ALU slice (AND, OR, ADD, less-select), processing one bit per clock, LSB first. It owns the slice's control inputs (op, b_invert, carry_in, less) and the carry feedback register, and performs the extra pass needed for set-less-than. Sits between the datapath register file and a requester that issues start/operand pairs; it is the area-minimal alternative to the 32-slice ripple ALU.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- alu_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes unsupported
- a_in  input  WIDTH  operand A, latched on accepted start
- b_in  input  WIDTH  operand B, latched on accepted start
- busy  output  1  high in RUN and FIX
- done  output  1  one-cycle pulse, result/flags valid from this cycle
- result  output  WIDTH  last completed result, held until next done
- carry_out  output  1  carry out of MSB (ADD/SUB/SLT), else 0
- overflow  output  1  signed overflow (ADD/SUB only), else 0
- zero  output  1  result == 0

## Operation
- Reset (async, rst_n=0): state IDLE; busy, done, result, carry_out, overflow, zero all 0; internal shift regs, bit counter, and carry reg cleared. Reset mid-operation aborts with no done.
- States: IDLE → RUN (start=1 at an edge in IDLE) → FIX (SLT only) or DONE → IDLE. DONE lasts exactly one cycle; start is ignored in RUN, FIX, and DONE, with no queuing.
- On acceptance: latch a_in, b_in, alu_op; counter=0; carry reg = 1 for SUB/SLT, 0 otherwise; b_invert = 1 for SUB/SLT.
- Slice op mapping: AND→00, OR→01, ADD/SUB/SLT→10 during RUN; less tied 0 during RUN.
- RUN, each edge: slice inputs a[cnt], b[cnt] (inverted if b_invert), carry reg; shift sum bit into the internal result shift register; carry reg ← slice carry_out; cnt++.
  - On the MSB cycle (cnt = WIDTH−1), also capture c_in_msb (carry into MSB) and sum_msb.
  - After WIDTH bits, go to DONE (FIX for SLT).
- FIX (SLT, 1 cycle): set = sum_msb XOR (c_in_msb XOR carry reg), giving a signed compare that corrects for overflow; internal result ← {WIDTH−1 zeros, set}.
- Entering DONE, the output registers update:
  - result ← internal result; zero ← (internal result == 0).
  - carry_out ← final carry for ADD/SUB/SLT, else 0.
  - overflow ← c_in_msb XOR final carry for ADD/SUB, else 0.
- Unsupported alu_op: sequence runs as for AND timing; result forced to 0, zero=1, carry_out=0, overflow=0.
- Outputs result/flags never change during busy; they change only on the edge entering DONE.

## Timing
- Edge E0 accepts start. Bits 0..WIDTH−1 are processed at edges E1..E_WIDTH.
- busy is high from after E0 until the edge entering DONE.
- Non-SLT: done high in the cycle after E_WIDTH (between E_WIDTH and E_WIDTH+1); latency WIDTH+1 cycles from E0 to done.
- SLT: FIX occupies E_WIDTH→E_WIDTH+1; done one cycle later (latency WIDTH+2).
- Back-to-back throughput: the next start is accepted at the edge after done (IDLE), so ops take WIDTH+2 cycles (WIDTH+3 for SLT).
- start held continuously starts a new op each time IDLE is reached.
- Operand changes after E0 have no effect.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 → result 0x80, overflow=1, carry_out=0, zero=0; done exactly 9 cycles after the accepting edge, busy high for 8 of those cycles.
- SUB 0x05−0x05 → result 0x00, zero=1, carry_out=1, overflow=0. SUB 0x03−0x05 → result 0xFE, carry_out=0.
- SLT 0xFE vs 0x03 → result 0x01. SLT 0x7F vs 0x80 (overflow case) → result 0x00. done at 10 cycles in both cases.
- AND 0xF0&0x3C → 0x30, then OR → 0xFC with start held high. Second op accepted only after done; a pulse on start during busy is dropped; result holds 0x30 until the OR completes.
- Assert rst_n=0 at bit 4 of an ADD → all outputs 0 immediately (async), no done; a fresh ADD 0x01+0x01 after release → 0x02.
- alu_op=011 with 0xFF, 0xFF → result 0x00, zero=1, done at 9 cycles.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer.
// Runs a WIDTH-bit AND/OR/ADD/SUB/SLT through a single one-bit ALU slice,
// one bit per clock, LSB first. The sequencer owns the slice controls
// (op select, b_invert, carry_in, less) and the carry feedback register.
// SLT needs one extra FIX cycle that turns the MSB sum and carries into a
// signed less-than bit.

// Protocol checker: completion pulse shape and output stability while busy.
module serial_alu_ctrl_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             busy,
  input logic             done,
  input logic [WIDTH-1:0] result
);

  // done only ever appears with busy already low.
  done_not_busy_a : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  // done is a single-cycle pulse.
  done_pulse_a : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  // The published result may not move while an operation is in flight.
  result_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
    (busy && $past(busy)) |-> $stable(result));

endmodule

module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Requester opcodes.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Slice output-mux selects.
  localparam logic [1:0] SL_AND  = 2'b00;
  localparam logic [1:0] SL_OR   = 2'b01;
  localparam logic [1:0] SL_SUM  = 2'b10;
  localparam logic [1:0] SL_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t              state_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [2:0]          op_r;
  logic [1:0]          slice_op_r;
  logic                b_invert_r;
  logic                carry_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-2:0]    res_r;        // bits already produced, MSB-aligned
  logic                c_in_msb_r;
  logic                sum_msb_r;

  logic                a_bit_s;
  logic                b_bit_s;
  logic                less_s;
  logic                slice_out_s;
  logic                slice_cout_s;
  logic [WIDTH-1:0]    res_shift_s;  // internal result after this bit
  logic                set_s;
  logic                is_arith_s;
  logic                is_addsub_s;
  logic                is_slt_s;
  logic                is_supported_s;

  // One-bit ALU slice: returns {carry_out, slice_out}.
  function automatic logic [1:0] slice_eval(
    input logic [1:0] op,
    input logic       a,
    input logic       b,
    input logic       binv,
    input logic       cin,
    input logic       less
  );
    logic b_eff;
    logic sum;
    logic cout;
    logic out;
    b_eff = b ^ binv;
    sum   = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
    case (op)
      SL_AND:  out = a & b_eff;
      SL_OR:   out = a | b_eff;
      SL_SUM:  out = sum;
      SL_LESS: out = less;
      default: out = 1'b0;
    endcase
    return {cout, out};
  endfunction

  // Slice op select for a requester opcode; unsupported codes run as AND.
  function automatic logic [1:0] slice_op_for(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_AND:                 sel = SL_AND;
      OP_OR:                  sel = SL_OR;
      OP_ADD, OP_SUB, OP_SLT: sel = SL_SUM;
      default:                sel = SL_AND;
    endcase
    return sel;
  endfunction

  // Subtract-type opcodes invert B and seed the carry with 1.
  function automatic logic sub_like(input logic [2:0] op);
    logic r;
    case (op)
      OP_SUB, OP_SLT: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  assign less_s = 1'b0;

  // Evaluate the slice on the current bit and form the shifted result.
  always_comb begin
    a_bit_s = a_r[cnt_r];
    b_bit_s = b_r[cnt_r];
    {slice_cout_s, slice_out_s} = slice_eval(slice_op_r, a_bit_s, b_bit_s,
                                             b_invert_r, carry_r, less_s);
    res_shift_s = {slice_out_s, res_r};
    // Signed less-than: MSB of the difference corrected by the MSB overflow.
    set_s = sum_msb_r ^ (c_in_msb_r ^ carry_r);
  end

  // Classify the latched opcode for the completion flags.
  always_comb begin
    is_arith_s     = 1'b0;
    is_addsub_s    = 1'b0;
    is_slt_s       = 1'b0;
    is_supported_s = 1'b1;
    case (op_r)
      OP_AND, OP_OR: begin
        is_supported_s = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        is_arith_s  = 1'b1;
        is_addsub_s = 1'b1;
      end
      OP_SLT: begin
        is_arith_s = 1'b1;
        is_slt_s   = 1'b1;
      end
      default: begin
        is_supported_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      op_r       <= 3'b000;
      slice_op_r <= SL_AND;
      b_invert_r <= 1'b0;
      carry_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      res_r      <= {(WIDTH-1){1'b0}};
      c_in_msb_r <= 1'b0;
      sum_msb_r  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= {WIDTH{1'b0}};
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r        <= a_in;
            b_r        <= b_in;
            op_r       <= alu_op;
            slice_op_r <= slice_op_for(alu_op);
            b_invert_r <= sub_like(alu_op);
            carry_r    <= sub_like(alu_op);
            cnt_r      <= {CNT_W{1'b0}};
            res_r      <= {(WIDTH-1){1'b0}};
            busy       <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RUN: begin
          res_r   <= res_shift_s[WIDTH-1:1];
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + 1'b1;
          if (cnt_r == LAST_BIT) begin
            c_in_msb_r <= carry_r;
            sum_msb_r  <= slice_out_s;
            cnt_r      <= {CNT_W{1'b0}};
            if (is_slt_s) begin
              state_r <= ST_FIX;
            end else begin
              state_r   <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              result    <= is_supported_s ? res_shift_s : {WIDTH{1'b0}};
              zero      <= is_supported_s ? (res_shift_s == {WIDTH{1'b0}}) : 1'b1;
              carry_out <= is_arith_s ? slice_cout_s : 1'b0;
              overflow  <= is_addsub_s ? (carry_r ^ slice_cout_s) : 1'b0;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end

        ST_FIX: begin
          res_r     <= {(WIDTH-1){1'b0}};
          state_r   <= ST_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          result    <= {{(WIDTH-1){1'b0}}, set_s};
          zero      <= ~set_s;
          carry_out <= carry_r;
          overflow  <= 1'b0;
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  serial_alu_ctrl_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

endmodule
